conv3x3_engine: RTL
===================

# conv3x3_engine

Downstream consumer of the 8x8 signed Q1.7 pixel memory in the 2D convolution processor. Once started, it reads the stored 8x8 image through the memory read port and convolves it with a 3x3 signed Q1.7 kernel. It streams the 6x6 valid-region results, saturated back to 8-bit Q1.7, through a valid/ready output handshake.

## Interface
- IMG_W, 8: image width in pixels
- IMG_H, 8: image height in pixels
- DW, 8: pixel and coefficient width (signed Q1.7)
- FRAC, 7: fractional bits
- AW, 6: memory address width (row*IMG_W + col)
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle frame start; honoured only in IDLE
- busy  out  1  high from start accept until done
- done  out  1  one-cycle pulse after last result handshake
- k_we  in  1  kernel coefficient write; honoured only when busy=0
- k_idx  in  4  coefficient index 0..8, row-major (ki*3+kj); 9..15 ignored
- k_data  in  8  signed coefficient
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  AW  memory read address
- mem_rdata  in  8  signed pixel, valid one cycle after mem_rd_en
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_data  out  8  signed Q1.7 result
- out_row, out_col  out  3 each  output position 0..5

## Operation
- FSM states: IDLE, FETCH, DRAIN, OUT, DONE.
- IDLE: start=1 clears the accumulator, sets r=c=k=0 and moves to FETCH.
- FETCH: for 9 cycles (k=0..8), drive mem_rd_en=1 and mem_addr=(r+k/3)*IMG_W+(c+k%3). After k=8, go to DRAIN.
- Accumulation: acc += mem_rdata*kernel[k-1] in the cycle after each read (FETCH k=1..8, then DRAIN).
- DRAIN: accumulate the 9th product, then go to OUT.
- OUT: out_valid=1; out_data, out_row and out_col hold stable until out_ready=1.
- Advance on handshake: c increments, wrapping 5→0 with r incrementing. Clear acc, then FETCH. After (r,c)=(5,5), go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Arithmetic:
  - each product is 16-bit signed Q2.14;
  - acc is 20-bit signed, so the sum cannot overflow;
  - result = acc >>> FRAC (arithmetic shift, floor);
  - the result saturates to [-128, 127].
- Kernel registers are preserved across frames and cleared only by reset. A k_we received while busy=1 is dropped.
- start received while busy=1 is ignored.
- rst_n=0 at any time, including mid-frame, forces IDLE next edge. Partial results are discarded and no done pulse is issued.

## Timing
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, out_valid=0, out_data=0, out_row=0, out_col=0, all kernel regs=0.
- start at cycle T gives the first mem_rd_en at T+1.
- Per output with out_ready=1: 9 FETCH + 1 DRAIN + 1 OUT = 11 cycles.
- A full frame with no backpressure takes 36*11 = 396 cycles. done is asserted at T+397.
- mem_rd_en is 0 outside FETCH. The memory must never see a write from this block.
- out_valid must not drop without a handshake. The output fields are registered, with no combinational path from out_ready.

## Structure
- Shared package conv_pkg: DW, FRAC, IMG_W, IMG_H, the state enum, and the SAT_MAX/SAT_MIN constants (127/-128).
- Sub-module sat_shift: a combinational 20-bit to 8-bit shift-and-saturate, reused later by other filter stages.
- The kernel register file (9x8) and the FSM stay in the top module.

## Test plan
- Kernel center=64 (0.5), others 0; image all 100 -> 36 results, each 50, in row-major (0,0)..(5,5) order; done at T+397.
- All coefficients 16 (0.125); image all 64 -> every out_data = 72 (9216>>>7).
- Saturation: all coefficients 127, image all 127 -> 127; all coefficients -128, image all 127 -> -128.
- Floor rounding: only k[0]=1, pixel(0,0)=-1 -> out(0,0)=-1; pixel(0,0)=+1 -> 0.
- Backpressure: hold out_ready=0 for 5 cycles at output (2,3) -> out_valid, out_data and position stay stable, with no mem_rd_en. Total cycles grow by exactly 5.
- Reset and guards:
  - rst_n=0 during FETCH of output 10 -> all reset values the next cycle; a new start rerun gives correct results from (0,0).
  - k_we while busy is ignored.
  - start while busy is ignored.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and address helper for the 3x3 convolution stages.
package conv_pkg;
  localparam int IMG_W   = 8;
  localparam int IMG_H   = 8;
  localparam int DW      = 8;
  localparam int FRAC    = 7;
  localparam int AW      = 6;
  localparam int ACC_W   = 20;
  localparam int PROD_W  = 16;
  localparam int KN      = 9;
  localparam int OUT_N   = IMG_W - 2;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUT, DONE} state_t;

  // Pixel address for kernel tap k (row-major) of the window anchored at (r, c).
  function automatic logic [AW-1:0] pix_addr(input logic [2:0] r, input logic [2:0] c,
                                             input logic [3:0] k);
    int unsigned ki;
    int unsigned kj;
    ki = int'(k) / 3;
    kj = int'(k) % 3;
    return AW'((int'(r) + ki) * IMG_W + int'(c) + kj);
  endfunction
endpackage

// File: rtl/conv3x3_engine_if.sv
// Memory read port and result stream of the convolution engine.
interface conv3x3_engine_if import conv_pkg::*; ();
  logic                 mem_rd_en;
  logic [AW-1:0]        mem_addr;
  logic signed [DW-1:0] mem_rdata;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic [2:0]           out_row;
  logic [2:0]           out_col;

  modport master (
    output mem_rd_en, mem_addr, out_valid, out_data, out_row, out_col,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, out_valid, out_data, out_row, out_col,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/conv3x3_engine_sat_shift.sv
// Q-format narrowing: arithmetic right shift by FRAC, then saturate to signed DW bits.
module sat_shift
  import conv_pkg::*;
(
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [DW-1:0]    o_sat
);
  logic signed [ACC_W-1:0] w_shift;

  assign w_shift = i_acc >>> FRAC;

  always_comb begin
    if (w_shift > ACC_W'(SAT_MAX))
      o_sat = DW'(SAT_MAX);
    else if (w_shift < ACC_W'(SAT_MIN))
      o_sat = DW'(SAT_MIN);
    else
      o_sat = w_shift[DW-1:0];
  end
endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 signed Q1.7 convolution over the stored 8x8 image, streaming the 6x6 valid region.
module conv3x3_engine
  import conv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 k_we,
  input  logic [3:0]           k_idx,
  input  logic signed [DW-1:0] k_data,
  conv3x3_engine_if.master     bus
);
  state_t                  r_state;
  logic [2:0]              r_row;
  logic [2:0]              r_col;
  logic [3:0]              r_k;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [DW-1:0]    r_kern [KN];

  logic [3:0]              w_kidx;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [DW-1:0]    w_sat;
  logic                    w_col_wrap;
  logic                    w_last;
  logic [2:0]              w_nrow;
  logic [2:0]              w_ncol;

  // Read data lags the strobe by one cycle, so FETCH applies the previous tap and DRAIN the last.
  assign w_kidx     = (r_state == DRAIN) ? r_k : r_k - 4'd1;
  assign w_prod     = bus.mem_rdata * r_kern[w_kidx];
  assign w_acc_next = r_acc + ACC_W'(w_prod);

  assign w_col_wrap = (r_col == 3'(OUT_N - 1));
  assign w_last     = w_col_wrap && (r_row == 3'(OUT_N - 1));
  assign w_ncol     = w_col_wrap ? 3'd0 : r_col + 3'd1;
  assign w_nrow     = w_col_wrap ? r_row + 3'd1 : r_row;

  sat_shift u_sat (
    .i_acc (w_acc_next),
    .o_sat (w_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_row         <= '0;
      r_col         <= '0;
      r_k           <= '0;
      r_acc         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_row   <= '0;
      bus.out_col   <= '0;
      for (int unsigned i = 0; i < KN; i++) r_kern[i] <= '0;
    end else begin
      done <= 1'b0;
      if (k_we && !busy && (k_idx < 4'(KN)))
        r_kern[k_idx] <= k_data;

      case (r_state)
        IDLE: begin
          if (start) begin
            busy          <= 1'b1;
            r_acc         <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_k           <= '0;
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr  <= pix_addr(3'd0, 3'd0, 4'd0);
            r_state       <= FETCH;
          end
        end
        FETCH: begin
          if (r_k != 4'd0) r_acc <= w_acc_next;
          if (r_k == 4'(KN - 1)) begin
            bus.mem_rd_en <= 1'b0;
            r_state       <= DRAIN;
          end else begin
            r_k          <= r_k + 4'd1;
            bus.mem_addr <= pix_addr(r_row, r_col, r_k + 4'd1);
          end
        end
        DRAIN: begin
          r_acc         <= w_acc_next;
          bus.out_data  <= w_sat;
          bus.out_row   <= r_row;
          bus.out_col   <= r_col;
          bus.out_valid <= 1'b1;
          r_state       <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (w_last) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= DONE;
            end else begin
              r_row         <= w_nrow;
              r_col         <= w_ncol;
              r_k           <= '0;
              r_acc         <= '0;
              bus.mem_rd_en <= 1'b1;
              bus.mem_addr  <= pix_addr(w_nrow, w_ncol, 4'd0);
              r_state       <= FETCH;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
